dispatch_ctrl: RTL and testbench
================================

# dispatch_ctrl

Sequencing controller in front of the dispatcher. It decides each cycle whether the decoded instruction may dispatch and allocates its reorder-buffer tag, which is the value the dispatcher forwards as the RS destination and regfile reorder. It tracks occupancy of the ROB, the reservation station (RS) and the load/store buffer (LSB) with credit counters, and it recovers from branch-mispredict flushes. It is the single source of the dispatch-enable strobe between the decoder and the dispatcher.

## Interface
- TAG_W, 4: ROB tag width; tag 0 is reserved as "no dependency / value ready".
- ROB_ENTRIES, 15: ROB capacity; must be ≤ 2^TAG_W − 1; valid tags are 1..ROB_ENTRIES.
- RS_ENTRIES, 8: RS capacity.
- LSB_ENTRIES, 8: LSB capacity.

- clk_in  input  1  sole clock, rising edge.
- rst_in  input  1  synchronous, active-low reset.
- rdy_in  input  1  global pause; low freezes all state.
- decoder_ctrl_valid_in  input  1  decoder holds a valid instruction.
- decoder_ctrl_is_mem_in  input  1  instruction goes to the LSB (load/store); 0 means RS.
- ctrl_decoder_ready_out  output  1  controller can accept an instruction this cycle.
- ctrl_dispatcher_en_out  output  1  dispatch fires this cycle.
- ctrl_dispatcher_tag_out  output  TAG_W  ROB tag allocated to the firing instruction.
- ctrl_rob_head_out  output  TAG_W  tag of the oldest in-flight entry.
- rob_ctrl_commit_in  input  1  ROB retired its head entry.
- rs_ctrl_issue_in  input  1  one RS entry freed.
- lsb_ctrl_issue_in  input  1  one LSB entry freed.
- rob_ctrl_flush_in  input  1  mispredict flush; discard everything in flight.
- ctrl_rob_full_out  output  1  rob_count == ROB_ENTRIES.
- ctrl_rob_empty_out  output  1  rob_count == 0.
- ctrl_err_out  output  1  sticky protocol-error flag.

## Operation
- Registered state:
  - tail (next tag to allocate) and head.
  - rob_count (0..ROB_ENTRIES), rs_count, lsb_count.
  - err.
  - FSM state ∈ {RUN, RECOVER}.
- Combinational ready:
  - ready = rdy_in & (state == RUN) & !rob_ctrl_flush_in & rob_count < ROB_ENTRIES & (decoder_ctrl_is_mem_in ? lsb_count < LSB_ENTRIES : rs_count < RS_ENTRIES).
  - fire = ready & decoder_ctrl_valid_in.
  - ctrl_dispatcher_en_out = fire.
  - ctrl_dispatcher_tag_out = tail.
- On fire:
  - tail advances by one, wrapping ROB_ENTRIES → 1; tag 0 is never produced.
  - rob_count and the selected RS or LSB count each increment by one.
- On commit: head advances by one with the same wrap, and rob_count decrements.
- On RS/LSB issue: the matching count decrements.
- Simultaneous events in one cycle:
  - fire plus commit: rob_count is unchanged, and head and tail both advance.
  - fire plus issue to the same unit: that unit's count is unchanged.
  - rs and lsb issue are independent of each other.
- Underflow: commit with rob_count == 0, or issue with the matching count 0.
  - The event is ignored and the count holds.
  - err is set and stays set until reset; flush does not clear it.
- FSM:
  - RUN → RECOVER when rob_ctrl_flush_in = 1 and rdy_in = 1. In that cycle fire = 0, and any commit or issue is discarded.
  - On entry to RECOVER: head = tail = 1, and all counts = 0.
  - RECOVER → RUN after exactly one cycle (rdy_in high); ready = 0 in RECOVER.
  - A flush asserted while in RECOVER re-enters RECOVER for one more cycle.
- rdy_in low:
  - No register changes, and all inputs are ignored, including flush.
  - fire = 0 and ready = 0.
- Status outputs: full, empty and head are decoded from registers only.

## Timing
- Reset values (rst_in low at a clock edge):
  - state RUN; tail = head = 1; all counts 0; err 0.
  - While rst_in is low, ready and fire are forced to 0.
  - Resulting outputs: ctrl_dispatcher_tag_out = 1, full = 0, empty = 1.
- Reset asserted mid-operation wins over every other event in the same cycle.
- ready and en have zero-cycle latency from valid; the tag is valid in the same cycle as en.
- A freed credit (commit or issue) is visible to ready in the next cycle, never the same cycle.
- Flush recovery: flush at cycle N; RECOVER at N+1; earliest new fire at N+2, with tag 1.
- Back-to-back fires: one per cycle, consecutive tags.

## Test plan
- Reset, then valid = 1, is_mem = 0 held 8 cycles, no issues → tags 1..8 fire; cycle 9 ready = 0 (RS full); rob_count = 8.
- Alternate is_mem with rs/lsb issue each cycle and commit each cycle after 15 dispatches:
  - tags run 1..15, then 1, 2, …, with 0 never produced.
  - full asserts at rob_count 15 and ready drops.
  - A commit in cycle N lets a fire happen in N+1.
- ROB full, commit and valid in the same cycle → no fire that cycle; fire next cycle with tag = old head; rob_count stays 15.
- 5 in flight, flush at cycle N with valid = 1 → en = 0 at N and N+1; at N+2 en = 1 with tag 1; empty = 1 at N+1.
- commit with rob_count 0, and rs_ctrl_issue_in with rs_count 0:
  - err rises the next cycle and counts stay 0.
  - err stays 1 through a later flush and clears only on reset.
- rdy_in low for 3 cycles while valid, commit and flush pulse → en = 0; tag, counts and state unchanged; operation resumes identically when rdy_in returns high.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// Dispatch sequencing controller: ROB tag allocation, ROB/RS/LSB credit tracking
// and one-cycle flush recovery in front of the dispatcher.
module dispatch_ctrl #(
  parameter int TAG_W       = 4,
  parameter int ROB_ENTRIES = 15,
  parameter int RS_ENTRIES  = 8,
  parameter int LSB_ENTRIES = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             decoder_ctrl_valid_in,
  input  logic             decoder_ctrl_is_mem_in,
  output logic             ctrl_decoder_ready_out,
  output logic             ctrl_dispatcher_en_out,
  output logic [TAG_W-1:0] ctrl_dispatcher_tag_out,
  output logic [TAG_W-1:0] ctrl_rob_head_out,
  input  logic             rob_ctrl_commit_in,
  input  logic             rs_ctrl_issue_in,
  input  logic             lsb_ctrl_issue_in,
  input  logic             rob_ctrl_flush_in,
  output logic             ctrl_rob_full_out,
  output logic             ctrl_rob_empty_out,
  output logic             ctrl_err_out
);

  localparam int ROB_CW = $clog2(ROB_ENTRIES + 1);
  localparam int RS_CW  = $clog2(RS_ENTRIES + 1);
  localparam int LSB_CW = $clog2(LSB_ENTRIES + 1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_RECOVER = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [TAG_W-1:0]    tail_r, head_r;
  logic [ROB_CW-1:0]   rob_count_r, rob_count_nxt_s;
  logic [RS_CW-1:0]    rs_count_r, rs_count_nxt_s;
  logic [LSB_CW-1:0]   lsb_count_r, lsb_count_nxt_s;
  logic                err_r;
  logic                ready_s, fire_s, active_s;
  logic                commit_ok_s, rs_iss_ok_s, lsb_iss_ok_s, underflow_s;
  logic                fire_rs_s, fire_lsb_s;

  // Tags wrap ROB_ENTRIES -> 1 so that tag 0 stays reserved for "ready".
  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] t);
    if (t == TAG_W'(ROB_ENTRIES)) tag_inc = TAG_W'(1);
    else                          tag_inc = t + TAG_W'(1);
  endfunction

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_in)     state_r <= ST_RUN;
    else if (rdy_in) state_r <= state_nxt_s;
  end

  // FSM next-state: any flush enters (or re-enters) RECOVER for one cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN:     if (rob_ctrl_flush_in) state_nxt_s = ST_RECOVER; else state_nxt_s = ST_RUN;
      ST_RECOVER: if (rob_ctrl_flush_in) state_nxt_s = ST_RECOVER; else state_nxt_s = ST_RUN;
      default:    state_nxt_s = ST_RUN;
    endcase
  end

  // FSM outputs: ready/fire, driven from registered credits only
  always_comb begin
    ready_s = 1'b0;
    if (rst_in && rdy_in && (state_r == ST_RUN) && !rob_ctrl_flush_in &&
        (rob_count_r < ROB_CW'(ROB_ENTRIES))) begin
      if (decoder_ctrl_is_mem_in) ready_s = (lsb_count_r < LSB_CW'(LSB_ENTRIES));
      else                        ready_s = (rs_count_r  < RS_CW'(RS_ENTRIES));
    end else begin
      ready_s = 1'b0;
    end
    fire_s = ready_s & decoder_ctrl_valid_in;
  end

  // Credit events; a flush cycle discards commits and issues entirely
  always_comb begin
    active_s     = rdy_in & ~rob_ctrl_flush_in;
    commit_ok_s  = active_s & rob_ctrl_commit_in & (rob_count_r != ROB_CW'(0));
    rs_iss_ok_s  = active_s & rs_ctrl_issue_in   & (rs_count_r  != RS_CW'(0));
    lsb_iss_ok_s = active_s & lsb_ctrl_issue_in  & (lsb_count_r != LSB_CW'(0));
    underflow_s  = active_s & ((rob_ctrl_commit_in & (rob_count_r == ROB_CW'(0))) |
                               (rs_ctrl_issue_in   & (rs_count_r  == RS_CW'(0)))  |
                               (lsb_ctrl_issue_in  & (lsb_count_r == LSB_CW'(0))));
    fire_rs_s    = fire_s & ~decoder_ctrl_is_mem_in;
    fire_lsb_s   = fire_s &  decoder_ctrl_is_mem_in;
  end

  // Next counts: simultaneous increment and decrement cancel out
  always_comb begin
    rob_count_nxt_s = rob_count_r;
    if (fire_s && !commit_ok_s)      rob_count_nxt_s = rob_count_r + ROB_CW'(1);
    else if (!fire_s && commit_ok_s) rob_count_nxt_s = rob_count_r - ROB_CW'(1);
    else                             rob_count_nxt_s = rob_count_r;

    rs_count_nxt_s = rs_count_r;
    if (fire_rs_s && !rs_iss_ok_s)      rs_count_nxt_s = rs_count_r + RS_CW'(1);
    else if (!fire_rs_s && rs_iss_ok_s) rs_count_nxt_s = rs_count_r - RS_CW'(1);
    else                                rs_count_nxt_s = rs_count_r;

    lsb_count_nxt_s = lsb_count_r;
    if (fire_lsb_s && !lsb_iss_ok_s)      lsb_count_nxt_s = lsb_count_r + LSB_CW'(1);
    else if (!fire_lsb_s && lsb_iss_ok_s) lsb_count_nxt_s = lsb_count_r - LSB_CW'(1);
    else                                  lsb_count_nxt_s = lsb_count_r;
  end

  // Pointer, credit and error registers; rdy_in low freezes everything
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      tail_r      <= TAG_W'(1);
      head_r      <= TAG_W'(1);
      rob_count_r <= ROB_CW'(0);
      rs_count_r  <= RS_CW'(0);
      lsb_count_r <= LSB_CW'(0);
      err_r       <= 1'b0;
    end else if (rdy_in) begin
      if (rob_ctrl_flush_in) begin
        tail_r      <= TAG_W'(1);
        head_r      <= TAG_W'(1);
        rob_count_r <= ROB_CW'(0);
        rs_count_r  <= RS_CW'(0);
        lsb_count_r <= LSB_CW'(0);
      end else begin
        if (fire_s)      tail_r <= tag_inc(tail_r);
        if (commit_ok_s) head_r <= tag_inc(head_r);
        rob_count_r <= rob_count_nxt_s;
        rs_count_r  <= rs_count_nxt_s;
        lsb_count_r <= lsb_count_nxt_s;
      end
      err_r <= err_r | underflow_s;
    end
  end

  assign ctrl_decoder_ready_out  = ready_s;
  assign ctrl_dispatcher_en_out  = fire_s;
  assign ctrl_dispatcher_tag_out = tail_r;
  assign ctrl_rob_head_out       = head_r;
  assign ctrl_rob_full_out       = (rob_count_r == ROB_CW'(ROB_ENTRIES));
  assign ctrl_rob_empty_out      = (rob_count_r == ROB_CW'(0));
  assign ctrl_err_out            = err_r;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based model of the in-flight ROB tags.
module tb_dispatch_ctrl;

  localparam int ROB_N = 15;
  localparam int RS_N  = 8;
  localparam int LSB_N = 8;

  logic       clk_s = 1'b0;
  logic       rst_s, rdy_s, valid_s, is_mem_s, commit_s, rs_iss_s, lsb_iss_s, flush_s;
  logic       ready_s, en_s, full_s, empty_s, err_s;
  logic [3:0] tag_s, head_s;

  int checks_r = 0;
  int passed_r = 0;

  // Reference model: queue of in-flight tags plus plain credit counters
  int rob_q[$];
  int rs_cnt_m, lsb_cnt_m, next_tag_m;
  bit recover_m, err_m;

  always #5 clk_s = ~clk_s;

  dispatch_ctrl dut (
    .clk_in                  (clk_s),
    .rst_in                  (rst_s),
    .rdy_in                  (rdy_s),
    .decoder_ctrl_valid_in   (valid_s),
    .decoder_ctrl_is_mem_in  (is_mem_s),
    .ctrl_decoder_ready_out  (ready_s),
    .ctrl_dispatcher_en_out  (en_s),
    .ctrl_dispatcher_tag_out (tag_s),
    .ctrl_rob_head_out       (head_s),
    .rob_ctrl_commit_in      (commit_s),
    .rs_ctrl_issue_in        (rs_iss_s),
    .lsb_ctrl_issue_in       (lsb_iss_s),
    .rob_ctrl_flush_in       (flush_s),
    .ctrl_rob_full_out       (full_s),
    .ctrl_rob_empty_out      (empty_s),
    .ctrl_err_out            (err_s)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    assert (obs === exp) passed_r++;
    else $error("FAIL %s: observed %0d expected %0d at %0t", name, obs, exp, $time);
  endtask

  task automatic model_reset();
    rob_q.delete();
    rs_cnt_m   = 0;
    lsb_cnt_m  = 0;
    next_tag_m = 1;
    recover_m  = 1'b0;
    err_m      = 1'b0;
  endtask

  // One clock cycle: drive inputs, check combinational and status outputs, advance model
  task automatic step(input logic rst, input logic rdy, input logic v, input logic m,
                      input logic c, input logic ri, input logic li, input logic fl);
    bit exp_ready, exp_fire;
    int exp_head;
    @(negedge clk_s);
    rst_s = rst; rdy_s = rdy; valid_s = v; is_mem_s = m;
    commit_s = c; rs_iss_s = ri; lsb_iss_s = li; flush_s = fl;
    #1;
    exp_ready = rst && rdy && !recover_m && !fl && (rob_q.size() < ROB_N) &&
                (m ? (lsb_cnt_m < LSB_N) : (rs_cnt_m < RS_N));
    exp_fire  = exp_ready && v;
    exp_head  = (rob_q.size() > 0) ? rob_q[0] : next_tag_m;
    chk("ready", {31'd0, ready_s}, {31'd0, exp_ready});
    chk("en",    {31'd0, en_s},    {31'd0, exp_fire});
    chk("tag",   {28'd0, tag_s},   next_tag_m);
    chk("head",  {28'd0, head_s},  exp_head);
    chk("full",  {31'd0, full_s},  {31'd0, rob_q.size() == ROB_N});
    chk("empty", {31'd0, empty_s}, {31'd0, rob_q.size() == 0});
    chk("err",   {31'd0, err_s},   {31'd0, err_m});
    @(posedge clk_s);
    if (!rst) begin
      model_reset();
    end else if (rdy) begin
      if (fl) begin
        rob_q.delete();
        rs_cnt_m = 0; lsb_cnt_m = 0; next_tag_m = 1; recover_m = 1'b1;
      end else begin
        recover_m = 1'b0;
        if (c)  begin if (rob_q.size() == 0) err_m = 1'b1; else void'(rob_q.pop_front()); end
        if (ri) begin if (rs_cnt_m == 0)  err_m = 1'b1; else rs_cnt_m--;  end
        if (li) begin if (lsb_cnt_m == 0) err_m = 1'b1; else lsb_cnt_m--; end
        if (exp_fire) begin
          rob_q.push_back(next_tag_m);
          next_tag_m = (next_tag_m % ROB_N) + 1;
          if (m) lsb_cnt_m++; else rs_cnt_m++;
        end
      end
    end
  endtask

  initial begin
    int pv, pc, pi, pf, pr;
    rst_s = 1'b0; rdy_s = 1'b1; valid_s = 1'b0; is_mem_s = 1'b0;
    commit_s = 1'b0; rs_iss_s = 1'b0; lsb_iss_s = 1'b0; flush_s = 1'b0;
    repeat (2) @(posedge clk_s);
    model_reset();

    // Reset held with valid high: nothing may fire
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill the RS: tags 1..8, then the ninth cycle stalls
    repeat (9) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rs_full_inflight", rob_q.size(), 8);

    // Loads into the LSB until the ROB is full, then ROB-full stall
    repeat (8) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Full ROB with commit and valid together: no fire now, fire next with old head
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Alternating RS/LSB traffic with issue and commit every cycle, wrapping tags
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'b1, 1'b1, i[0], 1'b1, 1'b1, 1'b1, 1'b0);

    // Flush with valid high, recovery cycle, then first fire with tag 1
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Underflows raise a sticky error that survives a flush
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // rdy_in low freezes state despite valid, commit and flush
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic in phases of differing pressure
    for (int ph = 0; ph < 6; ph++) begin
      pv = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 95 : 75;
      pc = (ph == 2) ? 15 : (ph == 3) ? 90 : 50;
      pi = (ph == 2) ? 20 : 55;
      pf = (ph == 4) ? 8 : 1;
      pr = (ph == 5) ? 70 : 95;
      for (int i = 0; i < 400; i++)
        step($urandom_range(999) != 0, $urandom_range(99) < pr, $urandom_range(99) < pv,
             $urandom_range(1) == 1, $urandom_range(99) < pc, $urandom_range(99) < pi,
             $urandom_range(99) < pi, $urandom_range(99) < pf);
    end

    $display("%0d/%0d checks passed", passed_r, checks_r);
    $finish;
  end

endmodule
